// File: rtl/i2c_codec_responder.sv
// Write-only I2C target modelling the audio codec control port: address match, ACK, 7-bit/9-bit register commit.
// Optional input glitch filter is enabled by defining I2C_GLITCH_FILTER_EN.
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR = 7'b0011010,
    parameter int         NUM_REGS = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    output logic       o_frame_err,
    output logic       o_busy,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        BYTE1,
        ACK1,
        BYTE2,
        ACK2,
        IGNORE
    } state_t;

    localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  byte1;
    logic [8:0]  regs [NUM_REGS];

    logic [1:0]  scl_sync;
    logic [1:0]  sda_sync;
    logic        scl_line;
    logic        sda_line;
    logic        scl_prev;
    logic        sda_prev;

    logic        start_det;
    logic        stop_det;
    logic        scl_rise;
    logic        scl_fall;
    logic        partial_frame;
    logic        addr_match;
    logic [6:0]  commit_addr;
    logic [8:0]  commit_data;

    // Lines reset to the idle bus level so leaving reset never looks like a bus event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], i_scl};
            sda_sync <= {sda_sync[0], i_sda};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic       scl_filt;
    logic       sda_filt;
    logic [1:0] scl_run;
    logic [1:0] sda_run;

    // A new level is accepted on its third consecutive sample; shorter pulses vanish.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
            scl_run  <= '0;
            sda_run  <= '0;
        end else begin
            if (scl_sync[1] == scl_filt) begin
                scl_run <= '0;
            end else if (scl_run == 2'd2) begin
                scl_filt <= scl_sync[1];
                scl_run  <= '0;
            end else begin
                scl_run <= scl_run + 2'd1;
            end
            if (sda_sync[1] == sda_filt) begin
                sda_run <= '0;
            end else if (sda_run == 2'd2) begin
                sda_filt <= sda_sync[1];
                sda_run  <= '0;
            end else begin
                sda_run <= sda_run + 2'd1;
            end
        end
    end

    assign scl_line = scl_filt;
    assign sda_line = sda_filt;
`else
    assign scl_line = scl_sync[1];
    assign sda_line = sda_sync[1];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_line;
            sda_prev <= sda_line;
        end
    end

    assign start_det     = scl_line && scl_prev && sda_prev && !sda_line;
    assign stop_det      = scl_line && scl_prev && !sda_prev && sda_line;
    assign scl_rise      = scl_line && !scl_prev;
    assign scl_fall      = !scl_line && scl_prev;
    assign partial_frame = (state == BYTE1) || (state == ACK1) || (state == BYTE2);
    assign addr_match    = (shift == {DEV_ADDR, 1'b0});
    assign commit_addr   = byte1[7:1];
    assign commit_data   = {byte1[0], shift};

    // Bus protocol engine; START/STOP win over any SCL edge seen in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            byte1       <= '0;
            o_sda_oe    <= 1'b0;
            o_wr_valid  <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            o_wr_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            if (start_det) begin
                o_frame_err <= partial_frame;
                state       <= ADDR;
                bit_cnt     <= '0;
                shift       <= '0;
                o_sda_oe    <= 1'b0;
                o_busy      <= 1'b0;
            end else if (stop_det) begin
                o_frame_err <= partial_frame;
                state       <= IDLE;
                bit_cnt     <= '0;
                o_sda_oe    <= 1'b0;
                o_busy      <= 1'b0;
            end else begin
                case (state)
                    ADDR, BYTE1, BYTE2: begin
                        if (scl_rise && (bit_cnt < 4'd8)) begin
                            shift   <= {shift[6:0], sda_line};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && (bit_cnt == 4'd8)) begin
                            bit_cnt <= '0;
                            if (state == ADDR) begin
                                if (addr_match) begin
                                    state    <= ACK_A;
                                    o_sda_oe <= 1'b1;
                                    o_busy   <= 1'b1;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else if (state == BYTE1) begin
                                byte1    <= shift;
                                state    <= ACK1;
                                o_sda_oe <= 1'b1;
                            end else begin
                                state    <= ACK2;
                                o_sda_oe <= 1'b1;
                            end
                        end
                    end
                    ACK_A, ACK1, ACK2: begin
                        if (scl_fall) begin
                            o_sda_oe <= 1'b0;
                            bit_cnt  <= '0;
                            if (state == ACK_A) begin
                                state <= BYTE1;
                            end else if (state == ACK1) begin
                                state <= BYTE2;
                            end else begin
                                state <= IGNORE;
                                // Out-of-range addresses were ACKed but are not stored or reported.
                                if (commit_addr < NUM_REGS_W) begin
                                    o_wr_valid <= 1'b1;
                                    o_wr_addr  <= commit_addr;
                                    o_wr_data  <= commit_data;
                                    for (int i = 0; i < NUM_REGS; i++) begin
                                        if (commit_addr == 7'(i)) begin
                                            regs[i] <= commit_data;
                                        end
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rd_addr == 4'(i)) begin
                o_rd_data = regs[i];
            end
        end
    end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Self-checking bench for i2c_codec_responder: bit-banged I2C master, frame-level reference model, per-cycle compare.
// Glitch expectations follow I2C_GLITCH_FILTER_EN.
module tb_i2c_codec_responder;

    localparam logic [6:0] DEV_ADDR = 7'b0011010;
    localparam int         NUM_REGS = 10;

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       frame_err;
    logic       busy;
    logic [3:0] rd_addr = '0;
    logic [8:0] rd_data;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_codec_responder #(
        .DEV_ADDR(DEV_ADDR),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_scl      (scl_drv),
        .i_sda      (sda_bus),
        .o_sda_oe   (sda_oe),
        .o_wr_valid (wr_valid),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_frame_err(frame_err),
        .o_busy     (busy),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] model_regs [16];
    wr_t        exp_wr_q [$];
    int         exp_wr_total = 0;
    int         exp_err_total = 0;
    int         wr_count = 0;
    int         err_count = 0;
    int         oe_cycles = 0;
    logic [6:0] last_addr = '0;
    logic [8:0] last_data = '0;
    logic [7:0] frame_q [$];
    logic [8:0] init_vals [10];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pulses are matched against the model's queue; between pulses the reported write must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sda_oe) oe_cycles++;
            if (wr_valid) begin
                wr_count++;
                if (exp_wr_q.size() != 0) begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    checkOutput("wr_addr", wr_addr, e.addr);
                    checkOutput("wr_data", wr_data, e.data);
                    last_addr = e.addr;
                    last_data = e.data;
                end
            end else begin
                checkOutput("held_wr_addr", wr_addr, last_addr);
                checkOutput("held_wr_data", wr_data, last_data);
            end
            if (frame_err) err_count++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, input bit glitch);
        cycles(3);
        sda_drv = b;
        cycles(7);
        scl_drv = 1'b1;
        if (glitch) begin
            cycles(2);
            sda_drv = 1'b0;
            cycles(2);
            sda_drv = b;
            cycles(1);
        end else begin
            cycles(5);
        end
        checkOutput("sda_oe_data_bit", sda_oe, 0);
        cycles(5);
        scl_drv = 1'b0;
    endtask

    task automatic bus_ack(input bit exp_ack, input bit exp_busy);
        cycles(3);
        sda_drv = 1'b1;
        cycles(7);
        scl_drv = 1'b1;
        cycles(5);
        checkOutput("ack", sda_oe, exp_ack);
        checkOutput("busy_in_ack", busy, exp_busy);
        cycles(5);
        scl_drv = 1'b0;
    endtask

    task automatic bus_byte(input logic [7:0] b, input bit exp_ack, input bit exp_busy, input int glitch_bit);
        for (int i = 7; i >= 0; i--) bus_bit(b[i], i == glitch_bit);
        bus_ack(exp_ack, exp_busy);
    endtask

    task automatic bus_start();
        cycles(3);
        sda_drv = 1'b1;
        cycles(7);
        scl_drv = 1'b1;
        cycles(5);
        sda_drv = 1'b0;
        cycles(5);
        scl_drv = 1'b0;
    endtask

    task automatic bus_stop();
        cycles(3);
        sda_drv = 1'b0;
        cycles(7);
        scl_drv = 1'b1;
        cycles(5);
        sda_drv = 1'b1;
        cycles(10);
    endtask

    task automatic frame_end();
        cycles(5);
        checkOutput("wr_pulse_count", wr_count, exp_wr_total);
        checkOutput("frame_err_count", err_count, exp_err_total);
        checkOutput("busy_after_stop", busy, 0);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            checkOutput($sformatf("rd_data[%0d]", i), rd_data, model_regs[i]);
        end
    endtask

    task automatic read_reg(input int idx, input logic [8:0] expected);
        rd_addr = 4'(idx);
        #1;
        checkOutput($sformatf("literal_reg%0d", idx), rd_data, expected);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model_regs[i] = '0;
        exp_wr_q.delete();
        last_addr = '0;
        last_data = '0;
    endtask

    // Frame-level model: the write byte of DEV_ADDR opens a frame that ACKs three bytes and commits once.
    task automatic applyStimulus(input bit restart_next);
        bit matched;
        int n;
        int a;
        logic [8:0] d;
        logic [7:0] b1;
        n = frame_q.size();
        matched = (n > 0) && (frame_q[0] == {DEV_ADDR, 1'b0});
        if (matched && n >= 3) begin
            b1 = frame_q[1];
            a = int'(b1) / 2;
            d = {b1[0], frame_q[2]};
            if (a < NUM_REGS) begin
                exp_wr_q.push_back('{addr: 7'(a), data: d});
                model_regs[a] = d;
                exp_wr_total++;
            end
        end
        if (matched && (n == 1 || n == 2)) exp_err_total++;
        bus_start();
        for (int i = 0; i < n; i++) bus_byte(frame_q[i], matched && (i < 3), matched, -1);
        if (!restart_next) begin
            bus_stop();
            frame_end();
        end
    endtask

    initial begin
        int base_wr;
        int base_err;
        int base_oe;
        int n;
        int r;
        bit rs;
        logic [7:0] b;

        init_vals = '{9'h017, 9'h1C3, 9'h07A, 9'h000, 9'h015, 9'h1A0, 9'h0C3, 9'h042, 9'h0FF, 9'h001};
        clear_model();

        cycles(3);
        checkOutput("reset_sda_oe", sda_oe, 0);
        checkOutput("reset_wr_valid", wr_valid, 0);
        checkOutput("reset_wr_addr", wr_addr, 0);
        checkOutput("reset_wr_data", wr_data, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_rd_data", rd_data, 0);
        rst_n = 1'b1;
        cycles(10);

        $display("[TB] basic write");
        frame_q = '{8'h34, 8'h00, 8'h97};
        applyStimulus(0);
        read_reg(0, 9'h097);
        checkOutput("literal_wr_addr", wr_addr, 7'd0);
        checkOutput("literal_wr_data", wr_data, 9'h097);
        checkOutput("literal_wr_count", wr_count, 1);

        $display("[TB] init sequence");
        base_wr = wr_count;
        for (int i = 0; i < 10; i++) begin
            b = {7'(i), init_vals[i][8]};
            frame_q = '{8'h34, b, init_vals[i][7:0]};
            applyStimulus(0);
        end
        checkOutput("literal_init_pulses", wr_count - base_wr, 10);
        read_reg(9, 9'h001);
        read_reg(4, 9'h015);
        read_reg(7, 9'h042);

        $display("[TB] foreign and read addresses");
        base_wr = wr_count;
        base_err = err_count;
        base_oe = oe_cycles;
        frame_q = '{8'h36, 8'h00, 8'h11};
        applyStimulus(0);
        frame_q = '{8'h35, 8'h02};
        applyStimulus(0);
        checkOutput("literal_no_oe", oe_cycles - base_oe, 0);
        checkOutput("literal_no_wr", wr_count - base_wr, 0);
        checkOutput("literal_no_err", err_count - base_err, 0);

        $display("[TB] out-of-range register and extra byte");
        frame_q = '{8'h34, 8'h1E, 8'h00};
        applyStimulus(0);
        frame_q = '{8'h34, 8'h00, 8'h97, 8'h55};
        applyStimulus(0);

        $display("[TB] partial frames");
        base_err = err_count;
        frame_q = '{8'h34, 8'h02};
        applyStimulus(0);
        frame_q = '{8'h34, 8'h02};
        applyStimulus(1);
        frame_q = '{8'h34, 8'h03, 8'h79};
        applyStimulus(0);
        checkOutput("literal_partial_errs", err_count - base_err, 2);
        read_reg(1, 9'h179);

        $display("[TB] short SDA glitch during data bit");
        bus_start();
        bus_byte(8'h34, 1, 1, -1);
        bus_byte(8'h00, 1, 1, -1);
`ifdef I2C_GLITCH_FILTER_EN
        exp_wr_q.push_back('{addr: 7'd0, data: 9'h0A5});
        model_regs[0] = 9'h0A5;
        exp_wr_total++;
        bus_byte(8'hA5, 1, 1, 7);
`else
        exp_err_total++;
        bus_byte(8'hA5, 0, 0, 7);
`endif
        bus_stop();
        frame_end();

        $display("[TB] reset during ACK1");
        bus_start();
        bus_byte(8'h34, 1, 1, -1);
        for (int i = 7; i >= 0; i--) bus_bit(i == 1, 0);
        cycles(3);
        sda_drv = 1'b1;
        cycles(7);
        scl_drv = 1'b1;
        cycles(5);
        checkOutput("ack1_before_reset", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("sda_oe_in_reset", sda_oe, 0);
        checkOutput("busy_in_reset", busy, 0);
        clear_model();
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            checkOutput($sformatf("cleared_reg%0d", i), rd_data, 0);
        end
        cycles(4);
        rst_n = 1'b1;
        cycles(10);
        frame_end();
        frame_q = '{8'h34, 8'h00, 8'h97};
        applyStimulus(0);

        $display("[TB] random frames");
        rs = 0;
        for (int k = 0; k < 30; k++) begin
            frame_q.delete();
            r = $urandom_range(0, 9);
            if (r < 7) b = 8'h34;
            else if (r == 7) b = 8'h35;
            else if (r == 8) b = 8'h36;
            else b = 8'($urandom_range(0, 255));
            frame_q.push_back(b);
            n = $urandom_range(1, 5);
            if (n > 1) frame_q.push_back({7'($urandom_range(0, 13)), 1'($urandom_range(0, 1))});
            for (int i = 2; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
            rs = (k != 29) && ($urandom_range(0, 4) == 0);
            applyStimulus(rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
